iprf: RTL and testbench

Integer physical register file serving the reservation station: it answers the RS GPR-read interface (`prf_rdens_rd0`/`prf_rdaddrs_rd0` → `prf_rddatas_rd1`) and absorbs the result-writeback ports (`iprf_wr_en_ro0`/`iprf_wr_pkt_ro0`). It sits between the RS issue pipe and the EX/MEM writeback buses. It provides one-cycle registered-address reads with same-cycle write forwarding, so an RS issue in rs1 sees correct operands in rs2.

---
 rtl/iprf.sv | 117 +++++++++++
 tb/tb_iprf.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iprf.sv
// Integer physical register file: NUM_RD registered-address read ports with
// same-cycle writeback forwarding, NUM_WR writeback ports, entry 0 hardwired zero.
package iprf_pkg;
  localparam int unsigned IPRF_NUM_ENTS   = 64;
  localparam int unsigned IPRF_NUM_WRITES = 2;
  localparam int unsigned PRF_ID_W        = $clog2(IPRF_NUM_ENTS);
  localparam int unsigned REG_DATA_W      = 32;

  typedef logic [PRF_ID_W-1:0]   t_prf_id;
  typedef logic [REG_DATA_W-1:0] t_rv_reg_data;

  typedef struct packed {
    t_prf_id      pdst;
    t_rv_reg_data data;
  } t_prf_wr_pkt;
endpackage

module iprf
  import iprf_pkg::*;
#(
  parameter int unsigned NUM_ENTS = IPRF_NUM_ENTS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = IPRF_NUM_WRITES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WR-1:0]   iprf_wr_en_ro0,
  input  t_prf_wr_pkt         iprf_wr_pkt_ro0 [NUM_WR],
  input  logic [NUM_RD-1:0]   prf_rdens_rd0,
  input  t_prf_id             prf_rdaddrs_rd0 [NUM_RD],
  output t_rv_reg_data        prf_rddatas_rd1 [NUM_RD]
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTS);
  typedef logic [IDX_W-1:0] t_idx;

  t_rv_reg_data mem_q     [NUM_ENTS];
  t_rv_reg_data mem_d     [NUM_ENTS];
  logic [NUM_RD-1:0] rden_q, rden_d;
  t_idx         rdaddr_q  [NUM_RD];
  t_idx         rdaddr_d  [NUM_RD];
  t_idx         wr_idx_c  [NUM_WR];
  t_rv_reg_data fwd_c     [NUM_RD];

  // Only the low index bits of an id select the entry.
  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_idx_c[p] = iprf_wr_pkt_ro0[p].pdst[IDX_W-1:0];
    end
  end

  // Array update: ascending port order so the highest port wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (iprf_wr_en_ro0[p] && (wr_idx_c[p] != '0)) begin
        mem_d[wr_idx_c[p]] = iprf_wr_pkt_ro0[p].data;
      end
    end
  end

  always_comb begin
    rden_d = prf_rdens_rd0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rdaddr_d[r] = prf_rdens_rd0[r] ? prf_rdaddrs_rd0[r][IDX_W-1:0] : rdaddr_q[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTS; i++) begin
        mem_q[i] <= '0;
      end
      rden_q <= '0;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
        rdaddr_q[r] <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      rden_q   <= rden_d;
      rdaddr_q <= rdaddr_d;
    end
  end

  // rd1: array lookup overridden by this cycle's writeback; disabled ports read 0.
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      fwd_c[r] = mem_q[rdaddr_q[r]];
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (iprf_wr_en_ro0[p] && (wr_idx_c[p] == rdaddr_q[r]) && (rdaddr_q[r] != '0)) begin
          fwd_c[r] = iprf_wr_pkt_ro0[p].data;
        end
      end
      prf_rddatas_rd1[r] = rden_q[r] ? fwd_c[r] : '0;
    end
  end

`ifdef ASSERT
  logic collide_c;

  always_comb begin
    collide_c = 1'b0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (iprf_wr_en_ro0[p] && iprf_wr_en_ro0[q] &&
            (wr_idx_c[p] == wr_idx_c[q]) && (wr_idx_c[p] != '0)) begin
          collide_c = 1'b1;
        end
      end
    end
  end

  a_wr_collide: assert property (@(posedge clk) disable iff (reset) !collide_c);
  a_wr_en_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(iprf_wr_en_ro0));
`endif

endmodule

// File: tb/tb_iprf.sv
// Directed and model-checked bench for iprf: reset, read latency, forwarding,
// write collision, zero register, concurrent reads, and random traffic.
module tb_iprf;
  import iprf_pkg::*;

  logic         clk;
  logic         reset;
  logic [1:0]   wr_en;
  t_prf_wr_pkt  wr_pkt  [2];
  logic [1:0]   rd_en;
  t_prf_id      rd_addr [2];
  t_rv_reg_data rd_data [2];

  int n_checks = 0;
  int n_errors = 0;

  t_rv_reg_data m [64];
  logic [1:0]   pen;
  t_prf_id      paddr [2];
  t_rv_reg_data exp_v;

  iprf #(.NUM_ENTS(64), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .iprf_wr_en_ro0  (wr_en),
    .iprf_wr_pkt_ro0 (wr_pkt),
    .prf_rdens_rd0   (rd_en),
    .prf_rdaddrs_rd0 (rd_addr),
    .prf_rddatas_rd1 (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_en = '0;
    rd_en = '0;
    for (int i = 0; i < 2; i++) begin
      wr_pkt[i]  = '0;
      rd_addr[i] = '0;
    end
  endtask

  // Advance to just after the next rising edge with all requests idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input int p, input logic [5:0] id, input logic [31:0] d);
    wr_en[p]       = 1'b1;
    wr_pkt[p].pdst = id;
    wr_pkt[p].data = d;
  endtask

  task automatic rd(input int r, input logic [5:0] id);
    rd_en[r]   = 1'b1;
    rd_addr[r] = id;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_p0", rd_data[0], 32'h0);
    chk("reset_p1", rd_data[1], 32'h0);

    // Release, hold writers off a cycle, then read id 5.
    cyc(); reset = 1'b0;
    cyc();
    cyc(); rd(0, 6'd5); rd(1, 6'd5);
    cyc(); @(negedge clk);
    chk("post_reset_id5_p0", rd_data[0], 32'h0);
    chk("post_reset_id5_p1", rd_data[1], 32'h0);

    // Basic write then read; disabled port returns 0.
    cyc(); wr(0, 6'd7, 32'hDEAD_BEEF);
    cyc(); rd(0, 6'd7);
    cyc(); @(negedge clk);
    chk("basic_p0", rd_data[0], 32'hDEAD_BEEF);
    chk("basic_p1_disabled", rd_data[1], 32'h0);
    rd_addr[0] = 6'd7;
    cyc(); rd_addr[0] = 6'd7;
    @(negedge clk);
    chk("basic_disabled_p0", rd_data[0], 32'h0);

    // Forwarding from the highest write port into rd1, then array holds it.
    cyc(); rd(1, 6'd9);
    cyc(); wr(1, 6'd9, 32'h1234); rd(0, 6'd9);
    @(negedge clk);
    chk("fwd_p1", rd_data[1], 32'h1234);
    cyc(); @(negedge clk);
    chk("fwd_array_p0", rd_data[0], 32'h1234);

    // Two ports hit id 3 in one cycle: port 1 wins, both forwarded and stored.
    cyc(); rd(1, 6'd3);
    cyc(); wr(0, 6'd3, 32'hAAAA); wr(1, 6'd3, 32'hBBBB); rd(0, 6'd3);
    @(negedge clk);
    chk("collide_fwd_p1", rd_data[1], 32'hBBBB);
    cyc(); @(negedge clk);
    chk("collide_array_p0", rd_data[0], 32'hBBBB);

    // Entry 0 ignores writes and is never forwarded.
    cyc(); rd(0, 6'd0); rd(1, 6'd0);
    cyc(); wr(0, 6'd0, 32'hFFFF); rd(0, 6'd0); rd(1, 6'd0);
    @(negedge clk);
    chk("zero_fwd_p0", rd_data[0], 32'h0);
    chk("zero_fwd_p1", rd_data[1], 32'h0);
    cyc(); @(negedge clk);
    chk("zero_array_p0", rd_data[0], 32'h0);
    chk("zero_array_p1", rd_data[1], 32'h0);

    // Both ports read id 4 while it is written in the same rd0 cycle.
    cyc(); rd(0, 6'd4); rd(1, 6'd4); wr(0, 6'd4, 32'h55);
    cyc(); @(negedge clk);
    chk("concur_p0", rd_data[0], 32'h55);
    chk("concur_p1", rd_data[1], 32'h55);

    // Mid-cycle reset with a read of id 7 outstanding.
    cyc(); rd(0, 6'd7); rd(1, 6'd9);
    cyc();
    #1;
    chk("pre_reset_p0", rd_data[0], 32'hDEAD_BEEF);
    chk("pre_reset_p1", rd_data[1], 32'h1234);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_p0", rd_data[0], 32'h0);
    chk("async_reset_p1", rd_data[1], 32'h0);
    cyc(); reset = 1'b0;
    cyc();
    cyc(); rd(0, 6'd7); rd(1, 6'd9);
    cyc(); @(negedge clk);
    chk("cleared_id7", rd_data[0], 32'h0);
    chk("cleared_id9", rd_data[1], 32'h0);

    // Random traffic against a reference array, narrow ids to force hazards.
    for (int i = 0; i < 64; i++) m[i] = '0;
    pen = '0;
    paddr[0] = '0;
    paddr[1] = '0;
    for (int c = 0; c < 10000; c++) begin
      cyc();
      for (int p = 0; p < 2; p++) begin
        wr_en[p]       = 1'($urandom_range(0, 1));
        wr_pkt[p].pdst = 6'($urandom_range(0, 7));
        wr_pkt[p].data = $urandom;
      end
      for (int r = 0; r < 2; r++) begin
        rd_en[r]   = 1'($urandom_range(0, 1));
        rd_addr[r] = 6'($urandom_range(0, 7));
      end
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        exp_v = '0;
        if (pen[r]) begin
          exp_v = m[paddr[r]];
          for (int p = 0; p < 2; p++) begin
            if (wr_en[p] && wr_pkt[p].pdst == paddr[r] && paddr[r] != 6'd0)
              exp_v = wr_pkt[p].data;
          end
        end
        chk($sformatf("rand_c%0d_p%0d", c, r), rd_data[r], exp_v);
      end
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_pkt[p].pdst != 6'd0) m[wr_pkt[p].pdst] = wr_pkt[p].data;
      end
      pen = rd_en;
      for (int r = 0; r < 2; r++) begin
        if (rd_en[r]) paddr[r] = rd_addr[r];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
